// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map and FSM encoding.
package intr_pkg;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_ISR  = 2'd2;
  localparam logic [1:0] ADDR_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-side interrupt and register port; master is the CPU, slave is the controller.
interface intr_ctrl_if #(parameter int ID_W = 3);

  logic            intr;
  logic            inta;
  logic [ID_W-1:0] irq_id;
  logic            irq_id_valid;
  logic            wr_en;
  logic [1:0]      wr_addr;
  logic [31:0]     wr_data;
  logic [1:0]      rd_addr;
  logic [31:0]     rd_data;

  modport master (
    input  intr, irq_id, irq_id_valid, rd_data,
    output inta, wr_en, wr_addr, wr_data, rd_addr
  );

  modport slave (
    input  inta, wr_en, wr_addr, wr_data, rd_addr,
    output intr, irq_id, irq_id_valid, rd_data
  );

endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder; purely combinational, no flow control.
module intr_prio_enc #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_IRQ-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  // Scan downward so the lowest set index is the last assignment to stick.
  always_comb begin
    id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered interrupt controller: irq rise -> pending at +1, intr at +2 (+2 more with INTR_CTRL_SYNC_EN).
// Single request/acknowledge/EOI handshake with the CPU; no nesting, later sources wait in pending.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  intr_ctrl_if.slave       cpu
);

  logic [N_IRQ-1:0] irq_s;
  logic [N_IRQ-1:0] prev;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] active;
  logic [N_IRQ-1:0] wr_bits;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] grant_bit;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  irq_id_q;
  logic             any_active;
  logic             grant;
  logic             wr_mask;
  logic             wr_pend;
  logic             wr_eoi;
  logic             intr_d;
  logic             svc_d;
  logic [31:0]      rd_q;
  logic             wr_data_unused;
  state_t           state;
  state_t           state_nxt;

`ifdef INTR_CTRL_SYNC_EN
  logic [N_IRQ-1:0] sync_q1;
  logic [N_IRQ-1:0] sync_q2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq_in;
`endif

  assign rise    = irq_s & ~prev;
  assign active  = pending & mask;
  assign wr_bits = cpu.wr_data[N_IRQ-1:0];
  assign wr_mask = cpu.wr_en && (cpu.wr_addr == ADDR_MASK);
  assign wr_pend = cpu.wr_en && (cpu.wr_addr == ADDR_PEND);
  assign wr_eoi  = cpu.wr_en && (cpu.wr_addr == ADDR_EOI);
  assign wr_data_unused = ^cpu.wr_data;

  intr_prio_enc #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_prio (
    .req (active),
    .id  (winner),
    .any (any_active)
  );

  // Grant uses the winner from pre-write pending, so a same-edge W1C cannot redirect it.
  assign grant     = (state == ST_REQ) && cpu.inta && any_active;
  assign grant_bit = grant ? (N_IRQ'(1) << winner) : '0;
  assign clr       = (wr_pend ? wr_bits : '0) | grant_bit;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev     <= '0;
      pending  <= '0;
      mask     <= '0;
      irq_id_q <= '0;
      rd_q     <= '0;
    end else begin
      prev    <= irq_s;
      pending <= rise | (pending & ~clr);
      if (wr_mask) mask <= wr_bits;
      if (grant) irq_id_q <= winner;
      case (cpu.rd_addr)
        ADDR_MASK: rd_q <= 32'(mask);
        ADDR_PEND: rd_q <= 32'(pending);
        ADDR_ISR:  rd_q <= 32'({svc_d, irq_id_q});
        default:   rd_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (any_active) state_nxt = ST_REQ;
      ST_REQ: begin
        if (grant)            state_nxt = ST_SERVICE;
        else if (!any_active) state_nxt = ST_IDLE;
      end
      ST_SERVICE: if (wr_eoi) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    intr_d = 1'b0;
    svc_d  = 1'b0;
    case (state)
      ST_REQ:     intr_d = 1'b1;
      ST_SERVICE: svc_d  = 1'b1;
      default: ;
    endcase
  end

  assign cpu.intr         = intr_d;
  assign cpu.irq_id_valid = svc_d;
  assign cpu.irq_id       = irq_id_q;
  assign cpu.rd_data      = rd_q;

endmodule
